gfx_cmd_scheduler: RTL
======================

# gfx_cmd_scheduler

Sequences CPU graphics commands into the G10k command path. Buffers 24-bit command words from the CPU in a small FIFO and issues them one at a time to the downstream units (clearer, text buffer, delta/palette controller, sprite controller) as an `out_cmd`/`out_start` pulse pair. Issues are spaced by a programmable gap and held while downstream is busy. Commands flagged as deferred are held until vertical blanking, so scroll and palette changes never tear mid-frame.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, 2..16.
- `GAP`, 4: idle cycles after each issue before the next one, 1..15.
- `clk` in 1: system clock, same domain as the VRAM and controllers.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_in` in 24: CPU command word; bit 23 = DEFER flag.
- `cmd_valid` in 1: one-cycle push strobe for `cmd_in`.
- `flush` in 1: synchronous FIFO clear.
- `vblank` in 1: level, high during vertical blanking.
- `dn_busy` in 1: level, downstream cannot accept a command.
- `out_cmd` out 24: issued word, held stable until the next issue.
- `out_start` out 1: one-cycle issue strobe.
- `full` out 1: FIFO full.
- `empty` out 1: FIFO empty.
- `level` out 5: occupancy, 0..DEPTH.
- `ovf_irq` out 1: one-cycle pulse when a push is dropped.
- `drain_irq` out 1: one-cycle pulse when the last queued command issues.

## Operation
- FSM states: IDLE, WAIT_VBL, ISSUE, GAP.
- **IDLE**
  - Stays in IDLE while `empty` or `dn_busy`.
  - If the head has DEFER=1 and `vblank`=0, goes to WAIT_VBL.
  - Otherwise goes to ISSUE.
- **WAIT_VBL**
  - Goes to ISSUE when `vblank`=1 and `dn_busy`=0.
  - The queue is strictly in-order: later non-deferred commands wait behind the held head.
- **ISSUE** (one cycle)
  - `out_start`=1 and `out_cmd`=head; the head is popped.
  - `drain_irq`=1 if `level` was 1.
  - Goes to GAP.
- **GAP**
  - Counts GAP cycles, then returns to IDLE.
  - `dn_busy` is not sampled during GAP.
- **Push**
  - `cmd_valid` with `full`=0: the word is written.
  - `cmd_valid` with `full`=1: the word is dropped and `ovf_irq` pulses.
  - `full` is evaluated before any same-cycle pop, so a push is dropped even while ISSUE pops.
- **Simultaneous push and pop when not full:** both occur and `level` is unchanged.
- **Flush:** empties the FIFO, overriding any same-cycle push.
  - If `flush` arrives in WAIT_VBL: goes to IDLE with no issue.
  - In ISSUE or GAP: the current issue and gap complete.
  - `drain_irq` does not pulse on flush.
- **Pointers:** wrap modulo DEPTH. `level` width is 5 bits, so DEPTH=16 is represented.
- **Reset (asynchronous, including mid-issue)**
  - FIFO emptied; FSM to IDLE; GAP counter cleared.
  - `out_cmd`=0, `out_start`=0, `full`=0, `empty`=1, `level`=0, `ovf_irq`=0, `drain_irq`=0.

## Timing
- All outputs are registered.
- Push at edge N: `level`/`empty` update after edge N.
- With an empty queue, not busy and DEFER=0: `out_start`=1 in the cycle after edge N+1 (2-cycle latency).
- Back-to-back issue spacing is GAP+2 cycles (ISSUE, GAP cycles, IDLE).
- Deferred head with a `vblank` rise sampled at edge M: `out_start` in the cycle after edge M+1.
- `dn_busy` is sampled only in IDLE and WAIT_VBL.
- `vblank` and `dn_busy` are synchronous to `clk`.

## Configuration
- `GFX_SCHED_VBL_DEFER_EN` defined: DEFER behaviour as above.
- Undefined:
  - WAIT_VBL is not built; bit 23 is ignored for scheduling.
  - Bit 23 is passed through unchanged in `out_cmd`.
  - `vblank` is unused.

## Structure
- Package `gfx_sched_pkg` holds:
  - the FSM state enum;
  - `CMD_W`=24;
  - `DEFER_BIT`=23;
  - the default DEPTH/GAP constants.
- Sub-module `gfx_cmd_fifo`: synchronous FIFO with push/pop/flush, `full`/`empty`/`level`, and the head word visible combinationally.
- The FSM and GAP counter live in the top.

## Test plan
- Push 0x012345 into an idle scheduler, `dn_busy`=0 → `out_start` two cycles later with `out_cmd`=0x012345; `drain_irq` pulses in the same cycle.
- Push 3 words back-to-back with GAP=4 → three `out_start` pulses 6 cycles apart, in push order.
- Push 0x800010 then 0x000020 with `vblank`=0 → nothing issues. Raise `vblank` → 0x800010 issues, then 0x000020 issues 6 cycles later. With the macro undefined → both issue immediately.
- Fill 8 entries with `dn_busy`=1, push a 9th → `ovf_irq` pulse, `level` stays 8. Release `dn_busy` → exactly 8 issues.
- Hold `dn_busy`=1 at `level`=3, pulse `flush` with a same-cycle push → `level`=0, `empty`=1, no issue and no `drain_irq`.
- Assert `rst` during ISSUE → all outputs reach their reset values immediately; no further `out_start` after release.

Source files
------------

// File: rtl/gfx_sched_pkg.sv
// Shared types and constants for the G10k command scheduler.
// The optional vblank deferral is enabled by defining GFX_SCHED_VBL_DEFER_EN.
package gfx_sched_pkg;

    localparam int CMD_W     = 24;
    localparam int DEFER_BIT = 23;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_GAP   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_ISSUE,
        ST_GAP
    } sched_state_t;

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Command FIFO: registered full/empty/level, head word visible combinationally.
// Flush clears everything and overrides a same-cycle push.
module gfx_cmd_fifo
    import gfx_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [4:0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_level;
    logic          r_full;
    logic          r_empty;
    logic          w_wr;
    logic          w_rd;
    logic [4:0]    w_level_nxt;

    // Full is the registered flag, so a push is refused even when a pop lands on the same edge.
    assign w_wr = i_push && !r_full && !i_flush;
    assign w_rd = i_pop && !r_empty && !i_flush;

    always_comb begin
        w_level_nxt = r_level;
        if (i_flush)
            w_level_nxt = '0;
        else if (w_wr && !w_rd)
            w_level_nxt = r_level + 5'd1;
        else if (w_rd && !w_wr)
            w_level_nxt = r_level - 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == 5'(DEPTH));
            r_empty <= (w_level_nxt == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule

// File: rtl/gfx_cmd_scheduler.sv
// Issues queued CPU graphics commands downstream with a fixed gap, holding while busy.
// Define GFX_SCHED_VBL_DEFER_EN to hold DEFER-flagged commands until vertical blanking.
module gfx_cmd_scheduler
    import gfx_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic              cmd_valid,
    input  logic              flush,
    input  logic              vblank,
    input  logic              dn_busy,
    output logic [CMD_W-1:0]  out_cmd,
    output logic              out_start,
    output logic              full,
    output logic              empty,
    output logic [4:0]        level,
    output logic              ovf_irq,
    output logic              drain_irq
);

    sched_state_t     r_state;
    logic [3:0]       r_gap_cnt;
    logic [CMD_W-1:0] r_out_cmd;
    logic             r_out_start;
    logic             r_ovf;
    logic             r_drain;
    logic [CMD_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [4:0]       w_level;
    logic             w_can_issue;
    logic             w_issue;

    gfx_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_pop   (w_issue),
        .i_flush (flush),
        .i_din   (cmd_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

`ifdef GFX_SCHED_VBL_DEFER_EN
    logic r_vbl;

    // vblank is registered once, so a rise sampled at edge M releases the head at edge M+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vbl <= 1'b0;
        else
            r_vbl <= vblank;
    end

    assign w_can_issue = !w_head[DEFER_BIT] || r_vbl;
`else
    logic w_unused;
    assign w_unused    = ^{vblank, w_head[DEFER_BIT]};
    assign w_can_issue = 1'b1;
`endif

    assign w_issue = ((r_state == ST_IDLE) || (r_state == ST_WAIT_VBL)) &&
                     !w_empty && !dn_busy && !flush && w_can_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_out_cmd   <= '0;
            r_out_start <= 1'b0;
            r_ovf       <= 1'b0;
            r_drain     <= 1'b0;
        end else begin
            r_out_start <= w_issue;
            r_drain     <= w_issue && (w_level == 5'd1);
            r_ovf       <= cmd_valid && w_full;
            if (w_issue)
                r_out_cmd <= w_head;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue)
                        r_state <= ST_ISSUE;
`ifdef GFX_SCHED_VBL_DEFER_EN
                    else if (!w_empty && !dn_busy && !flush)
                        r_state <= ST_WAIT_VBL;
`endif
                end
`ifdef GFX_SCHED_VBL_DEFER_EN
                ST_WAIT_VBL: begin
                    if (flush)
                        r_state <= ST_IDLE;
                    else if (w_issue)
                        r_state <= ST_ISSUE;
                end
`endif
                ST_ISSUE: begin
                    r_state   <= ST_GAP;
                    r_gap_cnt <= 4'(GAP - 1);
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0)
                        r_state <= ST_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_cmd   = r_out_cmd;
    assign out_start = r_out_start;
    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = w_level;
    assign ovf_irq   = r_ovf;
    assign drain_irq = r_drain;

endmodule
